// File: rtl/sq_sipo_latch_feed_if.sv
// Serial bit stream in, parallel word plus latch-enable strobe out.
// Carries no logic of its own; the timing is set by sq_sipo_latch_feed.
// No backpressure: the source paces bits with v and the sink must accept every en strobe.
interface sq_sipo_latch_feed_if #(
    parameter int WIDTH = 8
);
    logic             d;
    logic             v;
    logic             sof;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic             en;
    logic             busy;
    logic             err;

    // The serial source drives the bit stream and observes the framing status.
    modport master (
        output d, v, sof, clr,
        input  q, en, busy, err
    );

    // The framing stage consumes the bit stream and drives the latch bank.
    modport slave (
        input  d, v, sof, clr,
        output q, en, busy, err
    );
endinterface

// File: rtl/sq_sipo_latch_feed.sv
// Assembles WIDTH serial bits into a word and strobes en so a transparent latch bank captures it.
// q and en update on the edge that samples the last bit; en lasts exactly one cycle.
// No backpressure: v gaps stall the frame indefinitely, and a mid-frame sof restarts it and sets err.
module sq_sipo_latch_feed #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    sq_sipo_latch_feed_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-2:0] sr_q;
    logic [WIDTH-1:0] q_q;
    logic             en_q;
    logic             err_q;

    logic [WIDTH-2:0] sr_base;
    logic [WIDTH-1:0] word_d;
    logic [WIDTH-2:0] sr_d;
    logic             last_bit;

    // Shift the incoming bit in; a sof restarts from an empty register so d becomes bit 0.
    always_comb begin
        sr_base = bus.sof ? '0 : sr_q;
        if (MSB_FIRST) begin
            word_d = {sr_base, bus.d};
            sr_d   = word_d[WIDTH-2:0];
        end else begin
            word_d = {bus.d, sr_base};
            sr_d   = word_d[WIDTH-1:1];
        end
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Framing FSM with registered word, strobe and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            q_q     <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            en_q <= 1'b0;

            // A sof arriving mid-frame is the only error source and wins over clr.
            if (state_q == SHIFT && bus.v && bus.sof) begin
                err_q <= 1'b1;
            end else if (bus.clr) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // Bits without sof are dropped silently while idle.
                    if (bus.v && bus.sof) begin
                        sr_q    <= sr_d;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.v) begin
                        if (bus.sof) begin
                            // Discard the partial word and restart with d as bit 0.
                            sr_q  <= sr_d;
                            cnt_q <= CNT_W'(1);
                        end else if (last_bit) begin
                            // q only moves here, so the latches see a stable word while en is high.
                            q_q     <= word_d;
                            en_q    <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            sr_q  <= sr_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q    = q_q;
    assign bus.en   = en_q;
    assign bus.err  = err_q;
    assign bus.busy = (state_q == SHIFT);
endmodule

// File: doc/sq_sipo_latch_feed.md
# sq_sipo_latch_feed

Serial-in, parallel-out framing stage that assembles a WIDTH-bit word from a gated serial bit stream and presents it with a one-cycle enable strobe. It sits directly upstream of the team's transparent D-latch bank: q drives the latch data inputs and en drives the latch enables, so the latches only ever open on a complete, stable word. It also flags framing errors and reports whether a frame is in progress.

## Interface
- WIDTH, 8, parallel word width in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first serial bit lands in q[WIDTH-1]; 0 = first serial bit lands in q[0].

- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- d  in  1  serial data bit; sampled only when v=1.
- v  in  1  bit-valid qualifier.
- sof  in  1  start-of-frame; meaningful only with v=1; marks d as bit 0 of a new frame.
- clr  in  1  synchronous clear of err.
- q  out  WIDTH  last completed word; held stable between strobes.
- en  out  1  one-cycle strobe: q has just been updated with a new word.
- busy  out  1  high while a frame is partially received.
- err  out  1  sticky framing-error flag.

## Operation
- Two-state FSM: IDLE and SHIFT. Internal registers: WIDTH-1-bit shift register sr and bit counter cnt (0..WIDTH-1).
- Reset while rst_n=0, regardless of clk: state=IDLE, cnt=0, sr=0, q=0, en=0, busy=0, err=0. Reset mid-frame discards the partial word. No en is produced for it.
- IDLE:
  - v=1 and sof=1: load d as bit 0, cnt<=1, go to SHIFT.
  - v=1 and sof=0: bit ignored, no error.
  - v=0: hold.
- SHIFT:
  - v=0: hold; the frame stalls indefinitely with no timeout.
  - v=1 and sof=0, cnt<WIDTH-1: shift d in, cnt<=cnt+1.
  - v=1 and sof=0, cnt=WIDTH-1 (last bit): q<=assembled word including d, en<=1, cnt<=0, go to IDLE.
  - v=1 and sof=1 (framing error): err<=1, discard the partial word, treat d as bit 0 of a new frame, cnt<=1, stay in SHIFT. No en.
- Bit order:
  - MSB_FIRST=1: shift left, so q = {sr, d_last} and the first bit ends in q[WIDTH-1].
  - MSB_FIRST=0: shift right, so q = {d_last, sr} and the first bit ends in q[0].
- en is high for exactly one cycle per completed frame. It is never high two cycles in a row unless two frames complete on consecutive edges; with WIDTH>=2 that is impossible.
- busy = (state==SHIFT); it is combinational from state.
- q changes only on the edge that raises en.
- err:
  - Set only by a mid-frame sof.
  - Cleared by clr=1 on a rising edge.
  - Set has priority when both occur on the same edge.
  - Not cleared by frame completion.

## Timing
- Sampling: d, v, sof and clr are sampled on the rising edge.
- Latency: the last bit is sampled at edge N. q and en update at that same edge N and are visible during cycle N..N+1. en drops at edge N+1.
- Back-to-back frames: in the cycle where en=1 the FSM is already IDLE, so a sof with v=1 is accepted at edge N+1. Minimum frame period is WIDTH cycles.
- Downstream latch: while en=1, q is guaranteed stable for the full cycle, and q does not change at the edge where en falls.
- Throughput: one bit per cycle maximum; gaps in v are allowed at any point within a frame.

## Test plan
- Reset: assert rst_n=0 mid-frame after 3 bits, then release and send a clean frame -> all outputs 0 during reset; no en for the aborted frame; the next frame completes normally.
- WIDTH=8, MSB_FIRST=1: stream 1,0,1,1,0,0,1,0 with v=1 every cycle, sof on the first bit -> q=8'hB2, en high exactly one cycle, in the cycle after the 8th bit; busy high for 7 cycles.
- MSB_FIRST=0: send the same stream -> q=8'h4D.
- Gapped v: insert v=0 gaps of 1 to 5 cycles between bits of 8'hA5 -> q=8'hA5; en asserted once; busy stays high across the gaps.
- Framing error: after 4 bits assert sof with v=1, then send 8'h3C framed from that sof -> err=1; q=8'h3C; exactly one en. Then apply clr=1 for one edge -> err=0. Apply clr together with a new mid-frame sof -> err stays 1.
- Back-to-back: two frames 8'hFF then 8'h00 with the second sof in the en cycle -> two en pulses 8 cycles apart; q=8'hFF then 8'h00; v-without-sof bits while IDLE are ignored.
